mem_port_arbiter: RTL

//  Shares one single-port instruction/data RAM between the IF stage (read-only) and the MEM stage (read/write) of the ARM core.

---
 rtl/arm_mem_pkg.sv | 15 +
 rtl/arb_wait_counter.sv | 21 ++
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/arm_mem_pkg.sv
// Shared encodings for the IF/MEM RAM port arbiter: FSM states and grant IDs.
package arm_mem_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic GNT_IF  = 1'b0;
  localparam logic GNT_MEM = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ACCESS = ST_ACCESS,
    S_DONE   = ST_DONE
  } state_e;
endpackage

// File: rtl/arb_wait_counter.sv
// Loadable down-counter timing the RAM wait-state window; zero flags the last cycle.
module arb_wait_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between IF (read-only) and MEM (read/write).
// Define ARB_ROUND_ROBIN_EN to break IF/MEM ties by alternating instead of fixed MEM priority.
module mem_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  localparam int            CW       = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

  state_e state, state_nxt;
  logic   grant_q, we_q, pick, cnt_load, cnt_zero, last_cycle;

  arb_wait_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_INIT),
    .en       (state == S_ACCESS),
    .zero     (cnt_zero)
  );

  assign last_cycle = (state == S_ACCESS) && cnt_zero;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            last_grant <= GNT_MEM;
    else if (last_cycle) last_grant <= grant_q;
  end

  // On a tie, whoever was not served last goes first.
  always_comb begin
    pick = mem_req ? GNT_MEM : GNT_IF;
    if (if_req && mem_req) pick = (last_grant == GNT_MEM) ? GNT_IF : GNT_MEM;
  end
`else
  // MEM wins ties so a store never waits behind a stalled fetch.
  always_comb pick = mem_req ? GNT_MEM : GNT_IF;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    case (state)
      S_IDLE: if (if_req || mem_req) begin
        state_nxt = S_ACCESS;
        cnt_load  = 1'b1;
      end
      S_ACCESS: if (cnt_zero) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q   <= GNT_IF;
      we_q      <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      if (state == S_IDLE && (if_req || mem_req)) begin
        grant_q  <= pick;
        we_q     <= (pick == GNT_MEM) && mem_we;
        ram_addr <= (pick == GNT_MEM) ? mem_addr : if_addr;
        if (pick == GNT_MEM) ram_wdata <= mem_wdata;
      end
      if (last_cycle && !we_q) begin
        if (grant_q == GNT_MEM) mem_rdata <= ram_rdata;
        else                    if_rdata  <= ram_rdata;
      end
    end
  end

  // Decoded from state so an async reset drops the strobes immediately.
  assign ram_en    = (state == S_ACCESS);
  assign ram_we    = ram_en && we_q;
  assign if_ready  = (state == S_DONE) && (grant_q == GNT_IF);
  assign mem_ready = (state == S_DONE) && (grant_q == GNT_MEM);
endmodule
